cell_fetch: RTL

Cell fetch unit sitting directly upstream of the heap `memory` block: it turns a single "fetch cell at pointer" request from the evaluator into the sequence of single-word reads that `memory` serves. It returns the cell's header, first field and second field together, with a one-cycle done pulse. A cell occupies three descending words: header at `ptr`, field0 (car/data) at `ptr-1`, field1 (cdr/next pointer) at `ptr-2`.

---
 rtl/cell_fetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cell_fetch.sv
// Heap cell fetch: turns one "fetch cell at ptr" request into three single-word
// memory reads (header at ptr, field0 at ptr-1, field1 at ptr-2).
module cell_fetch #(
    parameter int MemTop = 255,
    parameter int MinPtr = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ptr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] header,
    output logic [15:0] car,
    output logic [15:0] cdr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HDR,
        WAIT_F0,
        WAIT_F1
    } state_t;

    localparam logic [15:0] TOP_ADDR = 16'(MemTop);
    localparam logic [15:0] MIN_ADDR = 16'(MinPtr);

    state_t      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] header_q, header_d;
    logic [15:0] car_q, car_d;
    logic [15:0] cdr_q, cdr_d;
    logic        ptr_ok;

    // Bounds check keeps ptr-2 from underflowing and ptr from leaving the heap.
    assign ptr_ok = (ptr >= MIN_ADDR) && (ptr <= TOP_ADDR);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        header_d   = header_q;
        car_d      = car_q;
        cdr_d      = cdr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (ptr_ok) begin
                        ptr_d      = ptr;
                        mem_addr_d = ptr;
                        mem_req_d  = 1'b1;
                        state_d    = WAIT_HDR;
                    end else begin
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        header_d = '0;
                        car_d    = '0;
                        cdr_d    = '0;
                    end
                end
            end
            WAIT_HDR: begin
                if (mem_ready) begin
                    header_d   = mem_data;
                    mem_addr_d = ptr_q - 16'd1;
                    mem_req_d  = 1'b1;
                    state_d    = WAIT_F0;
                end
            end
            WAIT_F0: begin
                if (mem_ready) begin
                    car_d      = mem_data;
                    mem_addr_d = ptr_q - 16'd2;
                    mem_req_d  = 1'b1;
                    state_d    = WAIT_F1;
                end
            end
            WAIT_F1: begin
                if (mem_ready) begin
                    cdr_d   = mem_data;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            header_q   <= '0;
            car_q      <= '0;
            cdr_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            header_q   <= header_d;
            car_q      <= car_d;
            cdr_q      <= cdr_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign header   = header_q;
    assign car      = car_q;
    assign cdr      = cdr_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule
